// File: rtl/dpll_nco.sv
// dpll_nco: NCO phase-locked to a 1-bit reference through a sampled phase detector and PI filter.
// Lock detector (FSM, reference-loss timeout, locked output) built only when DPLL_LOCK_DET_EN is defined.
module dpll_nco #(
  parameter int unsigned ACC_W    = 16,
  parameter int unsigned NOM_INC  = 16'h0400,
  parameter int unsigned KP_SHIFT = 4,
  parameter int unsigned KI_SHIFT = 8,
  parameter int unsigned LOCK_TOL = 16'h0100,
  parameter int unsigned LOCK_CNT = 16,
  parameter int unsigned TMO_W    = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in,
  output logic             out,
  output logic [ACC_W-1:0] phase,
  output logic [ACC_W-1:0] freq_word,
  output logic             locked
);

  localparam int unsigned IW = ACC_W + 2;
  localparam logic signed [IW-1:0] INTEG_MAX = IW'(1) << (ACC_W - 2);
  localparam logic signed [IW-1:0] INTEG_MIN = -INTEG_MAX;
  localparam logic signed [IW-1:0] FREQ_MAX  = (IW'(1) << (ACC_W - 1)) - IW'(1);
  localparam logic signed [IW-1:0] FREQ_MIN  = IW'(1);
  localparam logic signed [IW-1:0] NOM_W     = IW'(NOM_INC);

  // Reference synchroniser and rising-edge detector
  logic sync_a, sync_b, sync_d, ref_edge;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_a <= 1'b0;
      sync_b <= 1'b0;
      sync_d <= 1'b0;
    end else begin
      sync_a <= in;
      sync_b <= sync_a;
      sync_d <= sync_b;
    end
  end

  assign ref_edge = sync_b & ~sync_d;

  // Phase detector and PI loop filter
  logic signed [IW-1:0] err, err_ki, err_kp;
  logic signed [IW-1:0] integ_q, integ_sum, integ_d, freq_sum;
  logic [ACC_W-1:0]     freq_d;

  assign err    = {{2{phase[ACC_W-1]}}, phase};
  assign err_ki = err >>> KI_SHIFT;
  assign err_kp = err >>> KP_SHIFT;

  always_comb begin
    integ_sum = integ_q - err_ki;
    if (integ_sum > INTEG_MAX) begin
      integ_d = INTEG_MAX;
    end else if (integ_sum < INTEG_MIN) begin
      integ_d = INTEG_MIN;
    end else begin
      integ_d = integ_sum;
    end

    freq_sum = NOM_W + integ_d - err_kp;
    if (freq_sum > FREQ_MAX) begin
      freq_d = FREQ_MAX[ACC_W-1:0];
    end else if (freq_sum < FREQ_MIN) begin
      freq_d = FREQ_MIN[ACC_W-1:0];
    end else begin
      freq_d = freq_sum[ACC_W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      phase     <= '0;
      freq_word <= ACC_W'(NOM_INC);
      integ_q   <= '0;
    end else begin
      phase <= phase + freq_word;
      if (ref_edge) begin
        integ_q   <= integ_d;
        freq_word <= freq_d;
      end
    end
  end

  assign out = ~phase[ACC_W-1];

`ifdef DPLL_LOCK_DET_EN
  typedef enum logic [1:0] {StUnlock, StAcq, StLock} lock_state_e;

  localparam int unsigned CNT_W = $clog2(LOCK_CNT + 1);

  lock_state_e      state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic [ACC_W-1:0] abs_err;
  logic             in_win, far_out, tmo_exp, locked_q;

  // Most negative error has no positive twin; saturate its magnitude
  always_comb begin
    if (phase == {1'b1, {(ACC_W-1){1'b0}}}) begin
      abs_err = {1'b0, {(ACC_W-1){1'b1}}};
    end else if (phase[ACC_W-1]) begin
      abs_err = -phase;
    end else begin
      abs_err = phase;
    end
  end

  assign in_win  = IW'(abs_err) < IW'(LOCK_TOL);
  assign far_out = IW'(abs_err) >= IW'(4 * LOCK_TOL);
  assign tmo_exp = &tmo_q;

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    tmo_d   = tmo_exp ? tmo_q : tmo_q + 1'b1;
    if (ref_edge) begin
      tmo_d = '0;
      unique case (state_q)
        StUnlock: begin
          if (in_win) begin
            state_d = StAcq;
            count_d = CNT_W'(1);
          end
        end
        StAcq: begin
          if (in_win) begin
            count_d = count_q + 1'b1;
            if (count_q + 1'b1 >= CNT_W'(LOCK_CNT)) begin
              state_d = StLock;
            end
          end else begin
            state_d = StUnlock;
            count_d = '0;
          end
        end
        StLock: begin
          if (far_out) begin
            state_d = StUnlock;
            count_d = '0;
          end
        end
        default: begin
          state_d = StUnlock;
          count_d = '0;
        end
      endcase
    end else if (tmo_exp) begin
      state_d = StUnlock;
      count_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StUnlock;
      count_q  <= '0;
      tmo_q    <= '0;
      locked_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      tmo_q    <= tmo_d;
      locked_q <= (state_q == StLock);
    end
  end

  assign locked = locked_q;
`else
  logic unused_lock_cfg;
  assign unused_lock_cfg = ^{LOCK_TOL, LOCK_CNT, TMO_W};
  assign locked = 1'b0;
`endif

endmodule
